arbitration_nway_wrr: RTL

Parametrised N-way arbiter that succeeds the single-cycle round-robin arbiter. It adds per-requestor weights (consecutive grants before rotation) and a run-time selectable fixed-priority mode. It re-arbitrates on `grant_release` with no idle bubble and handles non-power-of-two requestor counts with true modulo wrap. It sits in front of shared resources such as memory ports and DMA channels, which hold a grant until they assert release.

---
 rtl/arbitration_nway_wrr.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/arbitration_nway_wrr.sv
// ---------------------------------------------------------------------------
// arbitration_nway_wrr
//
// N-way arbiter with two run-time selectable modes. In weighted round robin
// each requestor keeps the grant for up to weights[i] consecutive
// transactions before the grant rotates. In fixed priority the lowest set
// request index wins. A grant is held until the grantee pulses
// grant_release. When another request is pending, the next winner is
// registered on that same edge, so there is no idle cycle between grants.
// Requestor counts that are not a power of two wrap with a true modulo.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst_n          asynchronous active-low reset
//   mode           0 = weighted round robin, 1 = fixed priority (lowest index)
//   weights        packed per-requestor grant counts; field i = [i*W +: W]
//   requests       level request bits, one per requestor
//   grant_release  one-cycle pulse: the grantee has finished one transaction
//   grant_valid    a grant is active
//   grant          binary index of the grantee
//   grant_oh       one-hot grant; all zeros when idle
//   grant_credit   grants left for the current grantee, including the active one
// ---------------------------------------------------------------------------
module arbitration_nway_wrr #(
  parameter int  C_NUM_REQUESTORS      = 8,
  parameter int  C_WEIGHT_WIDTH        = 4,
  localparam int C_LOG2_NUM_REQUESTORS = $clog2(C_NUM_REQUESTORS)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       mode,
  input  logic [C_NUM_REQUESTORS*C_WEIGHT_WIDTH-1:0] weights,
  input  logic [C_NUM_REQUESTORS-1:0]                requests,
  input  logic                                       grant_release,
  output logic                                       grant_valid,
  output logic [C_LOG2_NUM_REQUESTORS-1:0]           grant,
  output logic [C_NUM_REQUESTORS-1:0]                grant_oh,
  output logic [C_WEIGHT_WIDTH-1:0]                  grant_credit
);

  localparam int N   = C_NUM_REQUESTORS;
  localparam int W   = C_WEIGHT_WIDTH;
  localparam int L   = C_LOG2_NUM_REQUESTORS;
  localparam int LP1 = L + 1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   grant_q, grant_d;
  logic [N-1:0]   grant_oh_q, grant_oh_d;
  logic [W-1:0]   credit_q, credit_d;
  logic [L-1:0]   last_ptr_q, last_ptr_d;

  // Unpack the weight bus into an array for readable selection.
  logic [W-1:0]   weight_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_weight
    assign weight_arr[gi] = weights[gi*W +: W];
  end

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  logic           rr_found;
  logic [L-1:0]   rr_idx;
  logic [LP1-1:0] cand;
  logic [L-1:0]   fp_idx;
  logic [L-1:0]   pick_idx;
  logic [N-1:0]   pick_oh;
  logic [W-1:0]   sel_weight;
  logic [W-1:0]   load_credit;

  // Round robin: scan last_ptr+1 .. last_ptr+N. last_ptr < N and the step is
  // at most N, so a single conditional subtract is an exact modulo and no
  // out-of-range index is ever produced. last_ptr always equals the current
  // grantee while granted, so the grantee is naturally searched last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_ptr_q} + LP1'(k);
      if (cand >= LP1'(N)) begin
        cand = cand - LP1'(N);
      end
      if (!rr_found && requests[cand[L-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[L-1:0];
      end
    end
  end

  // Fixed priority: descending scan so the lowest set index is written last.
  always_comb begin
    fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (requests[i]) begin
        fp_idx = L'(i);
      end
    end
  end

  assign pick_idx = mode ? fp_idx : rr_idx;
  assign pick_oh  = N'(1) << pick_idx;

  always_comb begin
    sel_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == L'(i)) begin
        sel_weight = weight_arr[i];
      end
    end
  end

  // A zero weight still grants once; fixed priority always grants once.
  assign load_credit = mode ? W'(1)
                     : ((sel_weight == '0) ? W'(1) : sel_weight);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    credit_d   = credit_q;
    last_ptr_d = last_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (|requests) begin
          state_d    = S_GRANTED;
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          credit_d   = load_credit;
          last_ptr_d = pick_idx;
        end
      end

      S_GRANTED: begin
        if (grant_release) begin
          if ((credit_q > W'(1)) && requests[grant_q] && !mode) begin
            // Same grantee still has credit in weighted mode.
            credit_d = credit_q - W'(1);
          end else if (|requests) begin
            // Rotation, or a fresh re-grant when the grantee is the only
            // requestor; both fall out of the same pick.
            grant_d    = pick_idx;
            grant_oh_d = pick_oh;
            credit_d   = load_credit;
            last_ptr_d = pick_idx;
          end else begin
            state_d    = S_IDLE;
            grant_oh_d = '0;
            credit_d   = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      credit_q   <= '0;
      last_ptr_q <= L'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      credit_q   <= credit_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign grant_valid  = (state_q == S_GRANTED);
  assign grant        = grant_q;
  assign grant_oh     = grant_oh_q;
  assign grant_credit = credit_q;

endmodule
